// File: rtl/char_pixel_shifter.sv
// ============================================================================
// char_pixel_shifter: font ROM addressing, cursor inversion and MSB-first
// glyph serialiser. Option macro: CURSOR_UNDERLINE_EN (underline cursor).
// Revision: 1.0
// ============================================================================
`default_nettype none

module char_pixel_shifter #(
   parameter int CHAR_BITS = 8,
   parameter int ROW_BITS  = 4,
   parameter int GLYPH_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load,
   input  logic [CHAR_BITS-1:0]          char_code,
   input  logic [ROW_BITS-1:0]           row,
   input  logic                          cursor,
   input  logic                          blink_on,
   output logic [CHAR_BITS+ROW_BITS-1:0] rom_addr,
   input  logic [GLYPH_W-1:0]            rom_dout,
   output logic                          pixel,
   output logic                          pixel_vld
);

   localparam int CNT_W = $clog2(GLYPH_W + 1);
   localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(GLYPH_W);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_zero = '0;

   logic               r_v1;
   logic               r_inv1;
   logic               r_v2;
   logic               r_inv2;
   logic [GLYPH_W-1:0] r_shreg;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_inv;

   // Valid/cursor flags ride alongside the ROM's one-cycle registered read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         r_v1     <= 1'b0;
         r_inv1   <= 1'b0;
         r_v2     <= 1'b0;
         r_inv2   <= 1'b0;
      end else begin
         if (load) begin
            rom_addr <= {char_code, row};
         end
         r_v1   <= load;
         r_inv1 <= load & cursor & blink_on;
         r_v2   <= r_v1;
         r_inv2 <= r_inv1;
      end
   end

`ifdef CURSOR_UNDERLINE_EN
   logic [ROW_BITS-1:0] r_row1;
   logic [ROW_BITS-1:0] r_row2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row1 <= '0;
         r_row2 <= '0;
      end else begin
         r_row1 <= row;
         r_row2 <= r_row1;
      end
   end

   // Last two glyph rows are exactly those with every upper row bit set.
   assign w_inv = r_inv2 & (&r_row2[ROW_BITS-1:1]);
`else
   assign w_inv = r_inv2;
`endif

   // A fresh glyph always wins over the shift, giving gapless or truncated cells.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (r_v2) begin
         r_shreg <= rom_dout ^ {GLYPH_W{w_inv}};
         r_cnt   <= c_cnt_full;
      end else if (r_cnt != c_cnt_zero) begin
         r_shreg <= {r_shreg[GLYPH_W-2:0], 1'b0};
         r_cnt   <= r_cnt - c_cnt_one;
      end
   end

   assign pixel_vld = (r_cnt != c_cnt_zero);
   assign pixel     = pixel_vld & r_shreg[GLYPH_W-1];

endmodule

`default_nettype wire

// File: tb/tb_char_pixel_shifter.sv
// ============================================================================
// tb_char_pixel_shifter: scoreboard bench for char_pixel_shifter with a
// registered font ROM model. Honours CURSOR_UNDERLINE_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_char_pixel_shifter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  char_code = '0;
   logic [3:0]  row = '0;
   logic        cursor = 1'b0;
   logic        blink_on = 1'b0;
   logic [11:0] rom_addr;
   logic [7:0]  rom_dout;
   logic        pixel;
   logic        pixel_vld;

   char_pixel_shifter #(.CHAR_BITS(8), .ROW_BITS(4), .GLYPH_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .char_code (char_code),
      .row       (row),
      .cursor    (cursor),
      .blink_on  (blink_on),
      .rom_addr  (rom_addr),
      .rom_dout  (rom_dout),
      .pixel     (pixel),
      .pixel_vld (pixel_vld)
   );

   always #5 clk = ~clk;

   logic [7:0] font_mem [0:4095];
   always @(posedge clk) rom_dout <= font_mem[rom_addr];

   typedef struct {
      int stamp;
      bit pix;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   logic [11:0] last_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Each sampled cycle is either the next scheduled pixel or must be blank.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].stamp == cyc) begin
            mon_e = sb.pop_front();
            check_val("pixel_vld", {31'd0, pixel_vld}, 32'd1);
            check_val("pixel", {31'd0, pixel}, {31'd0, mon_e.pix});
         end else begin
            check_val("gap_vld", {31'd0, pixel_vld}, 32'd0);
            check_val("gap_pixel", {31'd0, pixel}, 32'd0);
         end
      end
   end

   // Called at a negedge; consumes exactly one clock.
   task automatic drive_cell(input logic [7:0] ch, input logic [3:0] r,
                             input bit cur, input bit blk);
      int         s;
      bit         inv;
      logic [7:0] g;
      s = cyc + 3;
      inv = cur & blk;
`ifdef CURSOR_UNDERLINE_EN
      inv = inv & (r >= 4'd14);
`endif
      g = font_mem[{ch, r}] ^ {8{inv}};
      while (sb.size() > 0 && sb[sb.size()-1].stamp >= s) sb.delete(sb.size() - 1);
      for (int k = 0; k < 8; k++) sb.push_back('{s + k, g[7-k]});
      load = 1'b1; char_code = ch; row = r; cursor = cur; blink_on = blk;
      @(negedge clk);
      check_val("rom_addr", {20'd0, rom_addr}, {20'd0, ch, r});
      last_addr = {ch, r};
      load = 1'b0; cursor = 1'b0; blink_on = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) font_mem[i] = 8'(i * 37 + 11);
      font_mem[12'h415] = 8'hA5;
      font_mem[12'h010] = 8'hFF;
      font_mem[12'h020] = 8'h00;
      font_mem[12'h035] = 8'h3C;
      font_mem[12'h03F] = 8'h3C;

      repeat (3) @(negedge clk);
      check_val("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
      check_val("rst_pixel", {31'd0, pixel}, 32'd0);
      check_val("rst_vld", {31'd0, pixel_vld}, 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // single cell
      drive_cell(8'h41, 4'h5, 1'b0, 1'b0);
      idle(11);

      // continuous FF then 00
      drive_cell(8'h01, 4'h0, 1'b0, 1'b0);
      idle(7);
      drive_cell(8'h02, 4'h0, 1'b0, 1'b0);
      idle(11);

      // cursor variants
      drive_cell(8'h03, 4'h5, 1'b1, 1'b1);
      idle(11);
      drive_cell(8'h03, 4'h5, 1'b1, 1'b0);
      idle(11);
      drive_cell(8'h03, 4'hF, 1'b1, 1'b1);
      idle(11);
      drive_cell(8'h03, 4'h5, 1'b0, 1'b1);
      idle(11);

      // early reload truncates the first cell
      drive_cell(8'h41, 4'h5, 1'b0, 1'b0);
      idle(3);
      drive_cell(8'h01, 4'h0, 1'b0, 1'b0);
      idle(11);

      // back-to-back loads: only the last glyph survives in full
      drive_cell(8'h02, 4'h0, 1'b0, 1'b0);
      drive_cell(8'h41, 4'h5, 1'b0, 1'b0);
      drive_cell(8'h03, 4'hF, 1'b1, 1'b1);
      idle(11);

      // idle: address must hold, output stays blank
      idle(40);
      check_val("idle_rom_addr", {20'd0, rom_addr}, {20'd0, last_addr});

      // asynchronous reset in the middle of a cell
      drive_cell(8'h41, 4'h5, 1'b0, 1'b0);
      idle(4);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_val("arst_rom_addr", {20'd0, rom_addr}, 32'd0);
      check_val("arst_pixel", {31'd0, pixel}, 32'd0);
      check_val("arst_vld", {31'd0, pixel_vld}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(12);
      check_val("post_rst_rom_addr", {20'd0, rom_addr}, 32'd0);

      drive_cell(8'h41, 4'h5, 1'b0, 1'b0);
      idle(12);
      check_val("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
